bcd_scan_driver: RTL
====================

BCD_SCAN_DRIVER -- requirements
Module: bcd_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz).
REQ-002 SHALL have parameter VALUE_W, default 14, width of binary input.
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port value  input  VALUE_W  unsigned binary to display.
REQ-006 SHALL have port load  input  1  single-cycle request to capture value.
REQ-007 SHALL have port busy  output  1  conversion in progress; load ignored while high.
REQ-008 SHALL have port done  output  1  one-cycle pulse when new digits are latched.
REQ-009 SHALL have port ovf  output  1  last captured value exceeded 9999.
REQ-010 SHALL have port BCD  output  4  BCD digit for currently selected slot, feeding the segment decoder.
REQ-011 SHALL have port an  output  4  active-low digit enables; an[0] = ones (rightmost).

Function
REQ-012 SHALL capture value when load=1 and state IDLE; values >9999 clamp to 9999 with ovf=1, else ovf=0.
REQ-013 SHALL use FSM IDLE -> CONV -> LATCH -> IDLE; CONV lasts exactly 14 cycles of shift-add-3 (double dabble), one bit per cycle, MSB first.
REQ-014 SHALL add 3 to any BCD nibble >=5 before each shift.
REQ-015 SHALL in LATCH copy the four result nibbles into display registers and assert done for that one cycle.
REQ-016 SHALL hold busy=1 in CONV and LATCH, 0 in IDLE; load-to-done latency 15 cycles (load sampled at edge k, done high after edge k+15).
REQ-017 SHALL ignore load while busy=1, including the LATCH cycle; no queuing.
REQ-018 SHALL keep displaying previous digits until LATCH; display never shows partial results.
REQ-019 SHALL run a prescaler 0..REFRESH_DIV-1; on wrap, slot index advances 0->1->2->3->0.
REQ-020 SHALL drive an = ~(1 << index) and BCD = digit[index], both registered, changing on the same edge.
REQ-021 SHALL run scanning continuously and independently of conversion.

Reset
REQ-022 SHALL on reset force: state IDLE, busy=0, done=0, ovf=0, all digits 0, prescaler 0, index 0, an=4'b1110, BCD=0.
REQ-023 SHALL on reset during CONV/LATCH abort conversion with no done pulse and digits cleared to 0.

Configuration
REQ-024 SHALL support macro LEADING_ZERO_BLANK_EN.
REQ-025 With LEADING_ZERO_BLANK_EN defined, SHALL drive an=4'b1111 during slots above the most-significant nonzero digit; digit 0 always lit (value 0 shows "0").
REQ-026 Without LEADING_ZERO_BLANK_EN, SHALL light all four slots, showing leading zeros.

Structure
REQ-027 SHALL place FSM state encodings, NUM_DIGITS=4, MAX_DISPLAY=9999 and default REFRESH_DIV in shared package display_pkg.
REQ-028 SHALL implement conversion in sub-module bin_to_bcd_seq (start/busy/done handshake, 16-bit BCD result); scanning stays in top.

Verification (REFRESH_DIV=4 for bench)
REQ-029 load value=1234 -> busy for 15 cycles, done pulse once; scan yields (an,BCD) = (1110,4),(1101,3),(1011,2),(0111,1) repeating every 16 cycles.
REQ-030 load value=12000 -> ovf=1, digits 9,9,9,9; subsequent load 42 -> ovf=0, digits 0,0,4,2.
REQ-031 load 5678 then load 1111 three cycles later and on LATCH cycle -> both ignored, digits 5,6,7,8, exactly one done.
REQ-032 load 4321, assert reset at CONV cycle 7 -> no done, an=1110, BCD=0, all digits 0, busy=0 next cycle.
REQ-033 LEADING_ZERO_BLANK_EN defined, load 7 -> slot 0 (an=1110,BCD=7), slots 1-3 an=1111; load 0 -> slot 0 shows 0.
REQ-034 Macro undefined, load 7 -> all slots lit, BCD 7,0,0,0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the BCD scan display driver.
// Blanking of leading zeros is enabled by LEADING_ZERO_BLANK_EN.
package display_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_LATCH = 2'd2
  } conv_state_e;

  localparam int NUM_DIGITS      = 4;
  localparam int MAX_DISPLAY     = 9999;
  localparam int REFRESH_DIV_DEF = 100000;
  localparam int BIN_W           = 14;
  localparam int BCD_W           = 4 * NUM_DIGITS;
  localparam int IDX_W           = $clog2(NUM_DIGITS);
  localparam int CNT_W           = $clog2(BIN_W);

  // Double-dabble correction: bump every nibble >= 5 by 3.
  function automatic logic [BCD_W-1:0] add3_all(
    input logic [BCD_W-1:0] b
  );
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per cycle, MSB first.
// Handshake: start in IDLE, busy through CONV/LATCH, done in LATCH.
module bin_to_bcd_seq
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] sr_q, sr_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] adj;

  assign adj = add3_all(acc_q);
  assign bcd = acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        busy          = 1'b1;
        {acc_d, sr_d} = {adj, sr_q} << 1;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LAST)
          state_d = S_LATCH;
      end
      S_LATCH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/bcd_scan_driver.sv
// Four-digit multiplexed BCD display driver with clamped binary capture.
// Define LEADING_ZERO_BLANK_EN to blank slots above the top nonzero digit.
module bcd_scan_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEF,
  parameter int VALUE_W     = BIN_W
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  output logic               busy,
  output logic               done,
  output logic               ovf,
  output logic [3:0]         BCD,
  output logic [3:0]         an
);

  localparam int PW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(REFRESH_DIV - 1);

  logic             start_q;
  logic [BIN_W-1:0] bin_q;
  logic             over;
  logic             accept;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;

  logic [NUM_DIGITS-1:0][3:0] disp_q;
  logic [PW-1:0]              presc_q;
  logic [IDX_W-1:0]           idx_q;
  logic [3:0]                 an_d;

  assign over   = 64'(value) > 64'(MAX_DISPLAY);
  // start_q covers the hand-off cycle before the converter reports busy.
  assign accept = load & ~busy & ~start_q;
  assign done   = conv_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= 1'b0;
      bin_q   <= '0;
      ovf     <= 1'b0;
    end else begin
      start_q <= accept;
      if (accept) begin
        bin_q <= over ? BIN_W'(MAX_DISPLAY) : BIN_W'(value);
        ovf   <= over;
      end
    end
  end

  bin_to_bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start_q),
    .bin   (bin_q),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (reset)
      disp_q <= '0;
    else if (conv_done)
      disp_q <= conv_bcd;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd;

  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (disp_q[i] != 4'd0)
        msd = IDX_W'(i);
    end
  end

  assign an_d = (idx_q > msd) ? 4'b1111
                              : ~(4'b0001 << idx_q);
`else
  assign an_d = ~(4'b0001 << idx_q);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      an      <= 4'b1110;
      BCD     <= 4'd0;
    end else begin
      an  <= an_d;
      BCD <= disp_q[idx_q];
      if (presc_q == PLAST) begin
        presc_q <= '0;
        idx_q   <= idx_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

endmodule
